snail_uart_tx: RTL and testbench

Write-snooping serial character output port for the SNAIL system. It watches the CPU's RAM write bus and captures every byte stored to a fixed I/O address, normally address 0, the character cell. Captured bytes go into a small FIFO and are shifted out as 8N1 serial frames on `txd`. The RAM still performs the write normally; this block only observes it and sits downstream of the CPU.

---
 rtl/snail_uart_tx_if.sv | 10 +
 rtl/snail_uart_tx.sv | 139 +++++++++++++
 tb/tb_snail_uart_tx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/snail_uart_tx_if.sv
// CPU RAM write bus as seen by snooping peripherals.
// The CPU side drives it; snoopers only observe.
interface snail_uart_tx_if;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdat;
   logic       ram_wr_;

   modport master (output ram_addr, ram_wdat, ram_wr_);
   modport slave  (input  ram_addr, ram_wdat, ram_wr_);
endinterface

// File: rtl/snail_uart_tx.sv
// Write-snooping character port: bytes stored to IO_ADDR are queued and
// shifted out on txd as 8N1 frames.
module snail_uart_tx #(
   parameter logic [7:0] IO_ADDR      = 8'h00,
   parameter int         CLKS_PER_BIT = 4,
   parameter int         FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   snail_uart_tx_if.slave                bus,
   output logic                          txd,
   output logic                          busy,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          ovf
);

   localparam int         AW   = $clog2(FIFO_DEPTH);
   localparam int         LW   = AW + 1;
   localparam logic [7:0] CMAX = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic [7:0]    cnt, cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          txd_nxt;
   logic          bit_end;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          cap, pop, push, drop;
   logic [7:0]    head;

   // ---------------- capture and FIFO ----------------
   assign cap       = !bus.ram_wr_ && (bus.ram_addr == IO_ADDR);
   assign fifo_full = (fifo_level == LW'(FIFO_DEPTH));
   // Pop decision uses the registered level, so a push into an empty
   // FIFO is only seen by the FSM one edge later.
   assign pop       = (state == IDLE) && (fifo_level != '0);
   assign push      = cap && (!fifo_full || pop);
   assign drop      = cap && !push;
   assign head      = mem[rd_ptr];
   assign busy      = (fifo_level != '0) || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.ram_wdat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         ovf        <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (drop) ovf <= 1'b1;
      end
   end

   // ---------------- transmit FSM ----------------
   assign bit_end = (cnt == CMAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         txd   <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shift <= shift_nxt;
         txd   <= txd_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_nxt = shift;
      case (state)
         IDLE: begin
            if (pop) begin
               state_nxt = START;
               cnt_nxt   = '0;
               shift_nxt = head;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_nxt   = '0;
               shift_nxt = {1'b0, shift[7:1]};
               if (idx == 3'd7) state_nxt = STOP;
               else             idx_nxt   = idx + 3'd1;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // txd is the registered image of what the next state will drive.
      case (state_nxt)
         START:   txd_nxt = 1'b0;
         DATA:    txd_nxt = shift_nxt[0];
         default: txd_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_snail_uart_tx.sv
// Directed bench for snail_uart_tx with C=4, depth 4.
module tb_snail_uart_tx;
   localparam int C = 4;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       txd, busy, fifo_full, ovf;
   logic [2:0] fifo_level;
   int         cyc = 0;
   int         errs = 0;
   int         checks = 0;

   snail_uart_tx_if bus ();

   snail_uart_tx #(.IO_ADDR(8'h00), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .txd        (txd),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .fifo_level (fifo_level),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // One bus cycle; returns 1ns after the capturing edge.
   task automatic cpu_cycle(input logic [7:0] a, input logic [7:0] d, input logic wn);
      @(negedge clk);
      bus.ram_addr = a;
      bus.ram_wdat = d;
      bus.ram_wr_  = wn;
      @(posedge clk); #1;
      bus.ram_wr_  = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Mid-bit sampling receiver, bounded wait for the start bit.
   task automatic rx_byte(output logic [7:0] b, output int t_fall);
      int n = 0;
      b = '0;
      t_fall = -1;
      while (txd !== 1'b0 && n < 400) begin tick(); n++; end
      if (txd !== 1'b0) begin
         chk("rx_start_timeout", {31'd0, txd}, 32'd0);
         return;
      end
      t_fall = cyc;
      repeat (C/2) tick();
      chk("rx_start_mid", {31'd0, txd}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (C) tick();
         b[i] = txd;
      end
      repeat (C) tick();
      chk("rx_stop", {31'd0, txd}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] frame;
      logic [7:0] rb;
      int         tf;
      int         tk;
      int         falls [5];
      int         lows;

      bus.ram_addr = 8'h00;
      bus.ram_wdat = 8'h00;
      bus.ram_wr_  = 1'b1;
      #12;
      chk("rst_txd",   {31'd0, txd},        32'd1);
      chk("rst_busy",  {31'd0, busy},       32'd0);
      chk("rst_level", {29'd0, fifo_level}, 32'd0);
      chk("rst_full",  {31'd0, fifo_full},  32'd0);
      chk("rst_ovf",   {31'd0, ovf},        32'd0);
      do_reset();

      // Single byte 0x41: exact per-cycle waveform.
      frame = {1'b1, 8'h41, 1'b0};
      cpu_cycle(8'h00, 8'h41, 1'b0);
      chk("sb_level_k", {29'd0, fifo_level}, 32'd1);
      chk("sb_busy_k",  {31'd0, busy},       32'd1);
      chk("sb_txd_k",   {31'd0, txd},        32'd1);
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("sb_txd", {31'd0, txd}, {31'd0, frame[i/C]});
         if (i == 0) chk("sb_level_pop", {29'd0, fifo_level}, 32'd0);
      end
      chk("sb_busy_last", {31'd0, busy}, 32'd1);
      tick();
      chk("sb_busy_end", {31'd0, busy}, 32'd0);
      chk("sb_txd_end",  {31'd0, txd},  32'd1);

      // Address filter and read cycle.
      cpu_cycle(8'h01, 8'h55, 1'b0);
      chk("af_01", {29'd0, fifo_level}, 32'd0);
      cpu_cycle(8'hFF, 8'h55, 1'b0);
      chk("af_ff", {29'd0, fifo_level}, 32'd0);
      cpu_cycle(8'h00, 8'h55, 1'b1);
      chk("af_rd", {29'd0, fifo_level}, 32'd0);
      lows = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (txd !== 1'b1) lows++; end
      chk("af_txd_idle", lows, 32'd0);
      chk("af_busy", {31'd0, busy}, 32'd0);

      // Overflow: 0x30..0x35 back to back.
      fork
         begin
            for (int i = 0; i < 6; i++) cpu_cycle(8'h00, 8'(8'h30 + i), 1'b0);
            chk("ov_ovf",   {31'd0, ovf},        32'd1);
            chk("ov_full",  {31'd0, fifo_full},  32'd1);
            chk("ov_level", {29'd0, fifo_level}, 32'd4);
         end
         begin
            for (int i = 0; i < 5; i++) begin
               rx_byte(rb, tf);
               falls[i] = tf;
               chk("ov_data", {24'd0, rb}, 32'(8'h30 + i));
            end
         end
      join
      for (int i = 1; i < 5; i++) chk("ov_spacing", falls[i] - falls[i-1], 32'd41);
      repeat (10) tick();
      chk("ov_idle_busy", {31'd0, busy}, 32'd0);
      chk("ov_sticky", {31'd0, ovf}, 32'd1);
      do_reset();
      chk("ov_cleared", {31'd0, ovf}, 32'd0);

      // Full plus pop: push lands on the edge that pops after STOP.
      cpu_cycle(8'h00, 8'hA0, 1'b0);
      tk = cyc;
      for (int i = 0; i < 4; i++) cpu_cycle(8'h00, 8'(8'hA1 + i), 1'b0);
      chk("fp_full", {31'd0, fifo_full}, 32'd1);
      while (cyc < tk + 41) tick();
      chk("fp_level_pre", {29'd0, fifo_level}, 32'd4);
      cpu_cycle(8'h00, 8'hA5, 1'b0);
      chk("fp_level", {29'd0, fifo_level}, 32'd4);
      chk("fp_ovf",   {31'd0, ovf},        32'd0);
      chk("fp_txd",   {31'd0, txd},        32'd0);
      do_reset();

      // Reset mid-frame during data bit 3 of 0xF0.
      cpu_cycle(8'h00, 8'hF0, 1'b0);
      tk = cyc;
      cpu_cycle(8'h00, 8'h11, 1'b0);
      cpu_cycle(8'h00, 8'h22, 1'b0);
      while (cyc < tk + 18) tick();
      chk("rm_level_pre", {29'd0, fifo_level}, 32'd2);
      chk("rm_txd_pre",   {31'd0, txd},        32'd0);
      #2 rst = 1'b1;
      #1;
      chk("rm_txd",   {31'd0, txd},        32'd1);
      chk("rm_busy",  {31'd0, busy},       32'd0);
      chk("rm_level", {29'd0, fifo_level}, 32'd0);
      chk("rm_full",  {31'd0, fifo_full},  32'd0);
      @(negedge clk); rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 60; i++) begin tick(); if (txd !== 1'b1) lows++; end
      chk("rm_no_stale", lows, 32'd0);
      chk("rm_busy_after", {31'd0, busy}, 32'd0);
      fork
         cpu_cycle(8'h00, 8'hA5, 1'b0);
         begin rx_byte(rb, tf); chk("rm_new_byte", {24'd0, rb}, 32'hA5); end
      join

      // Wrap-around stream of 20 bytes, 45 cycles apart.
      repeat (5) tick();
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               cpu_cycle(8'h00, 8'(i), 1'b0);
               repeat (44) @(posedge clk);
            end
         end
         begin
            for (int i = 0; i < 20; i++) begin
               rx_byte(rb, tf);
               chk("wr_data", {24'd0, rb}, 32'(i));
            end
         end
      join
      chk("wr_ovf", {31'd0, ovf}, 32'd0);
      repeat (10) tick();
      chk("wr_level", {29'd0, fifo_level}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
